// File: rtl/elem_condneg_seq.sv
// Purpose : element-wise conditional negate over a ROWS x COLS matrix, LANES elements per cycle.
// Latency : start accepted at edge T -> busy T+1..T+C, done pulse after edge T+C (C = ceil(N/LANES)).
// Backpr. : none; start is ignored outside IDLE, abort cancels a RUN with no done pulse.
//
// Ports: clk, reset (async, active-high), start, abort, a/cond (matrices latched on start;
//        only each cond element's MSB is used), busy (RUN), done (one-cycle pulse), f (registered result).
// Optional: define ELEM_CONDNEG_SAT_EN to saturate negation of the most-negative value to
//           the most-positive value instead of wrapping.
module elem_condneg_seq #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int WIDTH = 16,
    parameter int LANES = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               abort,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]   a,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]   cond,
    output logic                               busy,
    output logic                               done,
    output logic [ROWS:1][COLS:1][WIDTH-1:0]   f
);

    localparam int N    = ROWS * COLS;
    // idx never exceeds the start of the last chunk, so idx + LANES fits in IDXW bits
    localparam int IDXW = $clog2(N + LANES + 1);
    localparam logic [IDXW-1:0]  N_I      = IDXW'(N);
    localparam logic [IDXW-1:0]  LANES_I  = IDXW'(LANES);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_POS = ~MOST_NEG;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [IDXW-1:0]                idx;
    logic [N*WIDTH-1:0]             a_q;
    logic [N-1:0]                   neg_q;
    logic [N*WIDTH-1:0]             f_q;
    logic [N*WIDTH-1:0]             cond_flat;
    logic                           last_chunk;
    logic [LANES-1:0][IDXW-1:0]     lane_k;
    logic [LANES-1:0]               lane_vld;
    logic [LANES-1:0][WIDTH-1:0]    lane_a;
    logic [LANES-1:0]               lane_neg;
    logic [LANES-1:0][WIDTH-1:0]    lane_res;

    // Element k of a packed [ROWS:1][COLS:1] matrix sits at bits k*WIDTH +: WIDTH.
    assign cond_flat  = cond;
    assign f          = f_q;
    assign last_chunk = (idx + LANES_I) >= N_I;

    function automatic logic [WIDTH-1:0] condneg(input logic [WIDTH-1:0] x, input logic neg);
        logic [WIDTH-1:0] r;
        r = x;
        if (neg) begin
`ifdef ELEM_CONDNEG_SAT_EN
            if (x == MOST_NEG)
                r = MOST_POS;
            else
                r = ~x + WIDTH'(1);
`else
            r = ~x + WIDTH'(1);
`endif
        end
        return r;
    endfunction

    // Shared lane datapaths: each lane selects its element by shifting the latched operands.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_k[l]   = idx + IDXW'(l);
            lane_vld[l] = lane_k[l] < N_I;
            lane_a[l]   = WIDTH'(a_q >> (int'(lane_k[l]) * WIDTH));
            lane_neg[l] = 1'(neg_q >> lane_k[l]);
            lane_res[l] = '0;
            if (lane_vld[l])
                lane_res[l] = condneg(lane_a[l], lane_neg[l]);
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start wins over abort in IDLE because abort is only looked at in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (last_chunk)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decode straight from the state register
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Operand latch, chunk index and result register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx   <= '0;
            a_q   <= '0;
            neg_q <= '0;
            f_q   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                a_q <= a;
                for (int e = 0; e < N; e++)
                    neg_q[e] <= cond_flat[e*WIDTH + WIDTH - 1];
                idx <= '0;
            end
            if (state == S_RUN) begin
                // The chunk in flight is still written on the abort cycle.
                idx <= (abort || last_chunk) ? '0 : idx + LANES_I;
                for (int e = 0; e < N; e++)
                    for (int l = 0; l < LANES; l++)
                        if (lane_vld[l] && lane_k[l] == IDXW'(e))
                            f_q[e*WIDTH +: WIDTH] <= lane_res[l];
            end
        end
    end

endmodule

// File: doc/elem_condneg_seq.md
Name: elem_condneg_seq

Overview:
- Sequencing controller for element-by-element conditional negate over a ROWS x COLS fixed-point matrix.
- Latches operand and condition matrices on start, then walks elements in row-major order, LANES elements per cycle, through LANES shared condneg datapaths.
- Writes results into a registered output matrix and signals done.
- Trades area for latency against the fully parallel element array in the matrix datapath library.

Parameters:
- ROWS, 1, matrix row count (>=1).
- COLS, 1, matrix column count (>=1).
- WIDTH, 16, element width in bits, two's complement.
- LANES, 1, elements processed per cycle (1..ROWS*COLS).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; honoured only in IDLE.
- abort  input  1  synchronous cancel of an operation in progress.
- a  input  [ROWS:1][COLS:1][WIDTH-1:0]  operand matrix, sampled on accepted start.
- cond  input  [ROWS:1][COLS:1][WIDTH-1:0]  condition matrix; only the MSB of each element is used; sampled on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the last chunk is written.
- f  output logic [ROWS:1][COLS:1][WIDTH-1:0]  result matrix, registered.

Behaviour:
- Definitions:
  - N = ROWS*COLS; C = ceil(N/LANES).
  - Element index k maps to row k/COLS+1, col k%COLS+1; k=0 is [1][1].
- Reset (async, active-high):
  - state=IDLE; idx=0; busy=0; done=0; f=0; latched a/cond=0.
- States:
  - IDLE: start=1 latches a and the cond MSBs, sets idx=0, goes to RUN next cycle. f is not cleared.
  - RUN: each cycle computes elements idx..idx+LANES-1 and registers them into f.
    - Lanes with index >= N are masked; f beyond N is untouched.
    - idx += LANES. On the chunk containing index N-1, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency:
  - start accepted at edge T; busy high from T+1 through T+C.
  - First chunk's f valid after edge T+1; last chunk's f valid after edge T+C.
  - done high in cycle T+C+1 (after edge T+C); next start accepted at edge T+C+2 at the earliest.
- Arithmetic, per element:
  - cond MSB=0: f = a.
  - cond MSB=1: f = (~a + 1) mod 2^WIDTH.
  - No width growth; most-negative value wraps to itself (see Optional Feature).
- start while busy or done: ignored; latched operands unchanged.
- abort in RUN: next state IDLE, idx=0, done not pulsed. Already-written f elements hold; remaining elements keep prior values.
- abort in IDLE/DONE: no effect. If start and abort are both high in IDLE, start wins.
- Reset mid-RUN: immediate return to reset values, including f=0.
- a/cond may change freely after start is accepted; the operation uses latched copies.
- LANES >= N: single RUN cycle (C=1).

Optional Feature:
- Macro: ELEM_CONDNEG_SAT_EN.
- Defined: negating the most-negative value (1 followed by WIDTH-1 zeros) yields the most-positive value (0 followed by ones). All other values are unchanged.
- Undefined: two's complement wrap, i.e. -0x8000 = 0x8000 for WIDTH=16.

Test Plan:
- ROWS=2, COLS=2, WIDTH=16, LANES=1; a={1,2,3,4}, cond MSBs={0,1,0,1}; pulse start -> busy for 4 cycles; f={0x0001,0xFFFE,0x0003,0xFFFC}; done pulses once in cycle 5 after start edge.
- ROWS=2, COLS=3, LANES=4; all cond MSB=1, a=k+1 -> C=2 busy cycles; f[k]=-(k+1); masked lanes 6,7 write nothing; done pulses once.
- Most-negative a=0x8000 with cond MSB=1 -> f=0x8000 without ELEM_CONDNEG_SAT_EN; f=0x7FFF with it defined.
- start re-pulsed on the 2nd busy cycle with a changed -> ignored; results match the first latched a; only one done pulse.
- abort in the 2nd RUN cycle (LANES=1, N=4, f pre-cleared) -> IDLE next cycle; f[0], f[1] written, f[2], f[3] remain 0; no done; a new start afterwards completes normally.
- Assert reset asynchronously mid-RUN (between edges) -> busy=0, done=0, f=0 immediately; a start after reset release runs the full N elements.
